div_seq: RTL
============

# div_seq

Multi-cycle iterative divider, the inverse-direction companion to the single-cycle adder datapath in the ALU. It accepts a dividend/divisor pair over a valid/ready handshake, then performs one restoring subtract-and-shift step per cycle. It returns quotient and remainder over a second valid/ready handshake. It sits beside the adder in the ALU execute stage and serves DIV/REM-class operations.

## Interface
- `WIDTH`, 32, operand, quotient and remainder width; must be ≥ 2.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  divider idle and able to accept.
- `dividend`  in  WIDTH  numerator.
- `divisor`  in  WIDTH  denominator.
- `is_signed`  in  1  two's-complement operation; ignored when `DIV_SIGNED_EN` is undefined.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `quotient`  out  WIDTH  result quotient.
- `remainder`  out  WIDTH  result remainder.
- `div_by_zero`  out  1  divisor was zero for this result.

## Operation
- States:
  - IDLE: `in_ready`=1. An accept (`in_valid` & `in_ready`) latches the operands.
    - Divisor ≠ 0: go to RUN with step counter = 0.
    - Divisor = 0: go directly to DONE.
  - RUN: one step per cycle; after step WIDTH-1, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Step (restoring): partial remainder R (WIDTH+1 bits) = {R, next dividend MSB}; trial = R − divisor.
  - trial ≥ 0: R ← trial, quotient bit = 1.
  - trial < 0: R is kept, quotient bit = 0.
  - Dividend/quotient share one shift register.
- Signed mode: operands are converted to magnitudes on accept. On entry to DONE:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero: `quotient` = all ones, `remainder` = dividend unmodified, `div_by_zero`=1.
- Signed overflow (most-negative ÷ −1): `quotient` = most-negative, `remainder` = 0. This falls out of the magnitude path without a special case.
- Outputs are registered and stable throughout DONE, while `out_valid` is high and `out_ready` is low.
- Reset values: state IDLE; `out_valid`=0; `quotient`, `remainder`=0; `div_by_zero`=0; counter 0. `in_ready`=1 from the first cycle after `rst` falls.
- `rst` in RUN or DONE abandons the operation; no result is emitted.
- Inputs are ignored outside IDLE. `in_valid` may stay high; no accept occurs until IDLE.

## Timing
- Accept in cycle T (divisor ≠ 0): RUN occupies T+1..T+WIDTH; `out_valid` first high in T+WIDTH+1.
- Divide by zero: `out_valid` first high in T+1.
- Result handshake in cycle D: IDLE and `in_ready`=1 in D+1. This gives a minimum period of WIDTH+2 cycles per division; there is no accept in the same cycle as the output handshake.
- `in_ready` is a decode of the state register. It has no combinational path from any input.

## Configuration
- `DIV_SIGNED_EN` defined:
  - `is_signed` is honoured.
  - Sign capture, magnitude conversion and result negation are compiled in.
- `DIV_SIGNED_EN` undefined:
  - All operations are unsigned.
  - `is_signed` is unconnected internally.
  - Sign logic is absent.
  - Latency is unchanged.

## Structure
- Shared package `div_pkg`:
  - state enumeration (IDLE, RUN, DONE);
  - default `WIDTH`;
  - divide-by-zero quotient constant (all ones).
- Sub-module `div_step`: combinational single iteration.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next remainder and quotient bit.
  - Instantiated once and reused every RUN cycle.
- Counter width is $clog2(WIDTH).

## Test plan
- Unsigned 100 ÷ 7, WIDTH=32 → quotient 14, remainder 2; `out_valid` exactly 33 cycles after accept.
- 0xFFFFFFFF ÷ 1 unsigned → quotient 0xFFFFFFFF, remainder 0; then 5 ÷ 0 → quotient 0xFFFFFFFF, remainder 5, `div_by_zero`=1, `out_valid` 1 cycle after accept.
- With `DIV_SIGNED_EN`: −7 ÷ 2 → quotient −3 (0xFFFFFFFD), remainder −1. Then 0x80000000 ÷ −1 signed → quotient 0x80000000, remainder 0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → outputs stable, `in_ready`=0 throughout; release → IDLE next cycle and a second accept succeeds.
- Assert `rst` at RUN step 15 → `out_valid` never rises for that operation; after reset, 9 ÷ 3 → quotient 3, remainder 0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states, default width and
// the divide-by-zero quotient fill.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Replicated across the full quotient width on a zero divisor.
    localparam logic DIV_ZERO_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] part_rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quot_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // The extra top bit of trial is the borrow, i.e. the sign of R - divisor.
    assign shifted  = {part_rem, next_bit};
    assign trial    = {1'b0, shifted} - {2'b00, divisor};
    assign quot_bit = ~trial[WIDTH+1];
    assign rem_next = quot_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider with valid/ready handshakes on both sides.
// Define DIV_SIGNED_EN to compile in two's-complement support via is_signed.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             accept;
    logic             last_step;
    logic             zero_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] r_raw;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    assign accept    = in_valid & in_ready;
    assign zero_div  = (divisor == '0);
    assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));
    assign q_raw     = {acc[WIDTH-2:0], step_q};
    assign r_raw     = step_rem;

`ifdef DIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;
    logic neg_r;

    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor  : divisor;
    assign q_fin = neg_q ? -q_raw : q_raw;
    assign r_fin = neg_r ? -r_raw : r_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fin = q_raw;
    assign r_fin = r_raw;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .part_rem (part),
        .next_bit (acc[WIDTH-1]),
        .divisor  (dvsr),
        .rem_next (step_rem),
        .quot_bit (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_nxt unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = zero_div ? DONE : RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Dividend and quotient share acc: each step shifts a dividend bit out
    // of the top and a quotient bit in at the bottom.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            count       <= '0;
            acc         <= '0;
            part        <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        count <= '0;
                        acc   <= a_mag;
                        part  <= '0;
                        dvsr  <= b_mag;
                        if (zero_div) begin
                            quotient    <= {WIDTH{DIV_ZERO_QUOT_BIT}};
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    acc   <= q_raw;
                    part  <= step_rem;
                    count <= count + CW'(1);
                    if (last_step) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
